// File: rtl/gbe_rx_framer_if.sv
// Receive framer bus: GMII receive inputs on one side, the framed MAC byte
// stream, verdict pulses and frame counters on the other.
interface gbe_rx_framer_if;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  mac_rxd;
  logic        mac_rxdv;
  logic        mac_rxpacketok;
  logic        mac_rxpacketbad;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  // Framer side: consumes GMII, produces the MAC stream and verdicts.
  modport master (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
    output mac_rxd, mac_rxdv, mac_rxpacketok, mac_rxpacketbad,
    output frames_ok, frames_bad
  );

  // Environment side: drives GMII, observes the MAC stream and verdicts.
  modport slave (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er,
    input  mac_rxd, mac_rxdv, mac_rxpacketok, mac_rxpacketbad,
    input  frames_ok, frames_bad
  );
endinterface

// File: rtl/gbe_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS, length and rx_er,
// withholds the 4 FCS bytes and issues one good/bad verdict pulse per frame.
module gbe_rx_framer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic            mac_clk,
  input  logic            reset,
  gbe_rx_framer_if.master bus
);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_SKIP, S_IDLE, S_PRE, S_DATA, S_DROP, S_END
  } state_t;

  // Input register stage
  logic [7:0]  rxd_q;
  logic        dv_q;
  logic        er_q;

  state_t      state_reg;
  logic [2:0][7:0] dl_reg;      // dl_reg[0] newest, dl_reg[2] oldest
  logic [1:0]  fill_reg;        // number of valid bytes held in dl_reg
  logic [31:0] crc_reg;
  logic [10:0] len_reg;
  logic        bad_reg;

  logic [7:0]  mac_rxd_reg;
  logic        mac_rxdv_reg;
  logic        ok_pulse_reg;
  logic        bad_pulse_reg;
  logic [15:0] frames_ok_reg;
  logic [15:0] frames_bad_reg;

  logic [31:0] crc_next;
  logic [10:0] len_next;
  logic        frame_bad;

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Next CRC/length for the byte currently in the input register, and the
  // verdict the frame would get if this byte turned out to be its last.
  always_comb begin
    crc_next  = crc_byte(crc_reg, rxd_q);
    len_next  = (len_reg == 11'h7FF) ? len_reg : len_reg + 11'd1;
    frame_bad = bad_reg | er_q | (crc_next != CRC_RESIDUE) |
                (len_next < MIN_LEN) | (len_next > MAX_LEN);
  end

  // Input capture. Deliberately not reset: after a mid-frame reset the FSM
  // must still see dv high so it waits in SKIP for the frame to end.
  always_ff @(posedge mac_clk) begin
    rxd_q <= bus.gmii_rxd;
    dv_q  <= bus.gmii_rx_dv;
    er_q  <= bus.gmii_rx_er;
  end

  // Framing FSM with delay line, CRC/length tracking and registered outputs.
  // The input register plus dl_reg form the 4-byte delay: a byte leaves only
  // when a fourth newer byte is on gmii_rxd, which keeps the FCS in.
  always_ff @(posedge mac_clk) begin
    if (reset) begin
      state_reg      <= S_SKIP;
      dl_reg         <= '0;
      fill_reg       <= 2'd0;
      crc_reg        <= 32'hFFFF_FFFF;
      len_reg        <= 11'd0;
      bad_reg        <= 1'b0;
      mac_rxd_reg    <= 8'h00;
      mac_rxdv_reg   <= 1'b0;
      ok_pulse_reg   <= 1'b0;
      bad_pulse_reg  <= 1'b0;
      frames_ok_reg  <= 16'd0;
      frames_bad_reg <= 16'd0;
    end else begin
      mac_rxdv_reg  <= 1'b0;
      ok_pulse_reg  <= 1'b0;
      bad_pulse_reg <= 1'b0;
      case (state_reg)
        S_SKIP: begin
          if (!dv_q) state_reg <= S_IDLE;
        end
        S_IDLE, S_PRE: begin
          if (!dv_q) begin
            state_reg <= S_IDLE;
          end else if (rxd_q == 8'h55) begin
            state_reg <= S_PRE;
          end else if (rxd_q == 8'hD5) begin
            state_reg <= S_DATA;
            crc_reg   <= 32'hFFFF_FFFF;
            len_reg   <= 11'd0;
            bad_reg   <= 1'b0;
            fill_reg  <= 2'd0;
          end else begin
            state_reg <= S_SKIP;
          end
        end
        S_DATA: begin
          if (!dv_q) begin
            // SFD immediately followed by end of carrier: empty frame.
            state_reg      <= S_END;
            bad_pulse_reg  <= 1'b1;
            frames_bad_reg <= frames_bad_reg + 16'd1;
          end else begin
            crc_reg  <= crc_next;
            len_reg  <= len_next;
            bad_reg  <= bad_reg | er_q;
            dl_reg   <= {dl_reg[1], dl_reg[0], rxd_q};
            fill_reg <= (fill_reg == 2'd3) ? fill_reg : fill_reg + 2'd1;
            if (!bus.gmii_rx_dv) begin
              // This is the last byte of the frame: decide now.
              state_reg <= S_END;
              if (frame_bad) begin
                bad_pulse_reg  <= 1'b1;
                frames_bad_reg <= frames_bad_reg + 16'd1;
              end else begin
                ok_pulse_reg  <= 1'b1;
                frames_ok_reg <= frames_ok_reg + 16'd1;
              end
            end else if (len_next >= MAX_LEN) begin
              // The byte now arriving is number MAX_FRAME+1: stop output.
              state_reg <= S_DROP;
              bad_reg   <= 1'b1;
            end else if (fill_reg == 2'd3) begin
              mac_rxd_reg  <= dl_reg[2];
              mac_rxdv_reg <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!dv_q || !bus.gmii_rx_dv) begin
            state_reg      <= S_END;
            bad_pulse_reg  <= 1'b1;
            frames_bad_reg <= frames_bad_reg + 16'd1;
          end
        end
        S_END: begin
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_SKIP;
      endcase
    end
  end

  assign bus.mac_rxd         = mac_rxd_reg;
  assign bus.mac_rxdv        = mac_rxdv_reg;
  assign bus.mac_rxpacketok  = ok_pulse_reg;
  assign bus.mac_rxpacketbad = bad_pulse_reg;
  assign bus.frames_ok       = frames_ok_reg;
  assign bus.frames_bad      = frames_bad_reg;
endmodule

// File: tb/tb_gbe_rx_framer.sv
// Directed testbench for gbe_rx_framer: one task per scenario.
module tb_gbe_rx_framer;
  logic mac_clk = 1'b0;
  logic reset   = 1'b1;
  gbe_rx_framer_if bus();

  gbe_rx_framer #(.MIN_FRAME(64), .MAX_FRAME(1518)) dut (
    .mac_clk (mac_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 mac_clk = ~mac_clk;

  int num_checks = 0;
  int num_errors = 0;
  int cyc = 0;

  always @(posedge mac_clk) cyc = cyc + 1;

  // Frame under construction (DA..FCS) and monitor state.
  logic [7:0] frame_q[$];
  logic [7:0] out_q[$];
  int ok_cnt, bad_cnt, ok_cyc, bad_cyc, first_out, last_out, overlap;
  int t0;
  logic pre_rxdv, snap_rxdv;
  logic [7:0] snap_rxd;
  logic [15:0] snap_fok, snap_fbad;

  // Output monitor sampled mid-cycle.
  always @(negedge mac_clk) begin
    if (bus.mac_rxdv === 1'b1) begin
      out_q.push_back(bus.mac_rxd);
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (bus.mac_rxpacketok === 1'b1) begin ok_cnt++; ok_cyc = cyc; end
    if (bus.mac_rxpacketbad === 1'b1) begin bad_cnt++; bad_cyc = cyc; end
    if (bus.mac_rxdv === 1'b1 && (bus.mac_rxpacketok === 1'b1 || bus.mac_rxpacketbad === 1'b1))
      overlap++;
  end

  task automatic clear_mon();
    out_q.delete();
    ok_cnt = 0; bad_cnt = 0; ok_cyc = -1; bad_cyc = -1;
    first_out = -1; last_out = -1; overlap = 0;
  endtask

  // Payload bytes i&0xFF followed by a correct FCS (complemented CRC, LSB first).
  task automatic build_frame(input int n_payload);
    logic [31:0] c;
    logic [7:0] b;
    c = 32'hFFFF_FFFF;
    frame_q.delete();
    for (int i = 0; i < n_payload; i++) begin
      b = 8'(i);
      frame_q.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    frame_q.push_back(c[7:0]);
    frame_q.push_back(c[15:8]);
    frame_q.push_back(c[23:16]);
    frame_q.push_back(c[31:24]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge mac_clk); #1;
      bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0; bus.gmii_rxd = 8'h00;
    end
  endtask

  // Preamble + SFD + frame_q. er_idx / rst_idx select a byte for rx_er / reset (-1: none).
  task automatic drive_frame(input int er_idx, input int rst_idx);
    for (int i = 0; i < 8; i++) begin
      @(posedge mac_clk); #1;
      bus.gmii_rxd = (i == 7) ? 8'hD5 : 8'h55; bus.gmii_rx_dv = 1'b1; bus.gmii_rx_er = 1'b0;
    end
    for (int i = 0; i < frame_q.size(); i++) begin
      @(posedge mac_clk); #1;
      if (i == 0) t0 = cyc;
      bus.gmii_rxd = frame_q[i];
      bus.gmii_rx_er = (i == er_idx);
      reset = (i == rst_idx);
      if (rst_idx >= 0 && i == rst_idx) begin
        @(negedge mac_clk); pre_rxdv = bus.mac_rxdv;
      end
      if (rst_idx >= 0 && i == rst_idx + 1) begin
        @(negedge mac_clk);
        snap_rxdv = bus.mac_rxdv; snap_rxd = bus.mac_rxd;
        snap_fok = bus.frames_ok; snap_fbad = bus.frames_bad;
      end
    end
    @(posedge mac_clk); #1;
    bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge mac_clk); #1; reset = 1'b1;
    bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0;
    repeat (2) @(posedge mac_clk);
    #1; reset = 1'b0;
    idle(3);
  endtask

  task automatic test_reset();
    bus.gmii_rxd = 8'h00; bus.gmii_rx_dv = 1'b0; bus.gmii_rx_er = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge mac_clk);
    #1; reset = 1'b0;
    @(negedge mac_clk);
    num_checks++; if (bus.mac_rxd !== 8'h00) begin num_errors++; $display("FAIL reset_rxd: got %h want 00", bus.mac_rxd); end
    num_checks++; if (bus.mac_rxdv !== 1'b0) begin num_errors++; $display("FAIL reset_rxdv: got %b want 0", bus.mac_rxdv); end
    num_checks++; if (bus.mac_rxpacketok !== 1'b0) begin num_errors++; $display("FAIL reset_ok: got %b want 0", bus.mac_rxpacketok); end
    num_checks++; if (bus.mac_rxpacketbad !== 1'b0) begin num_errors++; $display("FAIL reset_bad: got %b want 0", bus.mac_rxpacketbad); end
    num_checks++; if (bus.frames_ok !== 16'd0) begin num_errors++; $display("FAIL reset_frames_ok: got %0d want 0", bus.frames_ok); end
    num_checks++; if (bus.frames_bad !== 16'd0) begin num_errors++; $display("FAIL reset_frames_bad: got %0d want 0", bus.frames_bad); end
    $display("reset: rxdv=%b frames_ok=%0d frames_bad=%0d", bus.mac_rxdv, bus.frames_ok, bus.frames_bad);
  endtask

  task automatic test_good_frame();
    int mism;
    do_reset(); clear_mon();
    build_frame(60);
    drive_frame(-1, -1);
    idle(8);
    mism = 0;
    foreach (out_q[i]) if (out_q[i] !== 8'(i)) mism++;
    num_checks++; if (out_q.size() != 60) begin num_errors++; $display("FAIL good_len: got %0d want 60", out_q.size()); end
    num_checks++; if (mism != 0) begin num_errors++; $display("FAIL good_data: %0d wrong bytes want 0", mism); end
    num_checks++; if (first_out != t0 + 5) begin num_errors++; $display("FAIL good_latency: got cycle %0d want %0d", first_out, t0 + 5); end
    num_checks++; if (last_out - first_out != 59) begin num_errors++; $display("FAIL good_contig: got span %0d want 59", last_out - first_out); end
    num_checks++; if (ok_cyc != t0 + 65) begin num_errors++; $display("FAIL good_ok_cycle: got %0d want %0d", ok_cyc, t0 + 65); end
    num_checks++; if (ok_cnt != 1 || bad_cnt != 0) begin num_errors++; $display("FAIL good_pulses: got ok=%0d bad=%0d want 1/0", ok_cnt, bad_cnt); end
    num_checks++; if (bus.frames_ok !== 16'd1) begin num_errors++; $display("FAIL good_frames_ok: got %0d want 1", bus.frames_ok); end
    num_checks++; if (overlap != 0) begin num_errors++; $display("FAIL good_overlap: got %0d want 0", overlap); end
    $display("good frame: out=%0d ok=%0d bad=%0d frames_ok=%0d", out_q.size(), ok_cnt, bad_cnt, bus.frames_ok);
  endtask

  task automatic test_crc_error();
    do_reset(); clear_mon();
    build_frame(60);
    frame_q[63] = frame_q[63] ^ 8'h01;
    drive_frame(-1, -1);
    idle(8);
    num_checks++; if (out_q.size() != 60) begin num_errors++; $display("FAIL crc_len: got %0d want 60", out_q.size()); end
    num_checks++; if (ok_cnt != 0 || bad_cnt != 1) begin num_errors++; $display("FAIL crc_pulses: got ok=%0d bad=%0d want 0/1", ok_cnt, bad_cnt); end
    num_checks++; if (bad_cyc != t0 + 65) begin num_errors++; $display("FAIL crc_bad_cycle: got %0d want %0d", bad_cyc, t0 + 65); end
    num_checks++; if (bus.frames_bad !== 16'd1 || bus.frames_ok !== 16'd0) begin num_errors++; $display("FAIL crc_counters: got ok=%0d bad=%0d want 0/1", bus.frames_ok, bus.frames_bad); end
    $display("crc error frame: out=%0d ok=%0d bad=%0d frames_bad=%0d", out_q.size(), ok_cnt, bad_cnt, bus.frames_bad);
  endtask

  task automatic test_rx_er();
    do_reset(); clear_mon();
    build_frame(96);
    drive_frame(10, -1);
    idle(8);
    num_checks++; if (out_q.size() != 96) begin num_errors++; $display("FAIL rxer_len: got %0d want 96", out_q.size()); end
    num_checks++; if (ok_cnt != 0 || bad_cnt != 1) begin num_errors++; $display("FAIL rxer_pulses: got ok=%0d bad=%0d want 0/1", ok_cnt, bad_cnt); end
    num_checks++; if (bus.frames_bad !== 16'd1) begin num_errors++; $display("FAIL rxer_frames_bad: got %0d want 1", bus.frames_bad); end
    $display("rx_er frame: out=%0d ok=%0d bad=%0d", out_q.size(), ok_cnt, bad_cnt);
  endtask

  task automatic test_runt();
    do_reset(); clear_mon();
    build_frame(59);
    drive_frame(-1, -1);
    idle(8);
    num_checks++; if (out_q.size() != 59) begin num_errors++; $display("FAIL runt_len: got %0d want 59", out_q.size()); end
    num_checks++; if (ok_cnt != 0 || bad_cnt != 1) begin num_errors++; $display("FAIL runt_pulses: got ok=%0d bad=%0d want 0/1", ok_cnt, bad_cnt); end
    num_checks++; if (bad_cyc != t0 + 64) begin num_errors++; $display("FAIL runt_bad_cycle: got %0d want %0d", bad_cyc, t0 + 64); end
    $display("runt frame: out=%0d ok=%0d bad=%0d", out_q.size(), ok_cnt, bad_cnt);
  endtask

  task automatic test_oversize();
    int mism;
    do_reset(); clear_mon();
    build_frame(1515);
    drive_frame(-1, -1);
    idle(8);
    mism = 0;
    foreach (out_q[i]) if (out_q[i] !== 8'(i)) mism++;
    num_checks++; if (out_q.size() != 1514) begin num_errors++; $display("FAIL over_len: got %0d want 1514", out_q.size()); end
    num_checks++; if (mism != 0) begin num_errors++; $display("FAIL over_data: %0d wrong bytes want 0", mism); end
    num_checks++; if (last_out != t0 + 5 + 1513) begin num_errors++; $display("FAIL over_last: got cycle %0d want %0d", last_out, t0 + 1518); end
    num_checks++; if (ok_cnt != 0 || bad_cnt != 1) begin num_errors++; $display("FAIL over_pulses: got ok=%0d bad=%0d want 0/1", ok_cnt, bad_cnt); end
    num_checks++; if (bad_cyc != t0 + 1520) begin num_errors++; $display("FAIL over_bad_cycle: got %0d want %0d", bad_cyc, t0 + 1520); end
    $display("oversize frame: out=%0d ok=%0d bad=%0d", out_q.size(), ok_cnt, bad_cnt);
  endtask

  task automatic test_max_frame();
    do_reset(); clear_mon();
    build_frame(1514);
    drive_frame(-1, -1);
    idle(8);
    num_checks++; if (out_q.size() != 1514) begin num_errors++; $display("FAIL max_len: got %0d want 1514", out_q.size()); end
    num_checks++; if (ok_cnt != 1 || bad_cnt != 0) begin num_errors++; $display("FAIL max_pulses: got ok=%0d bad=%0d want 1/0", ok_cnt, bad_cnt); end
    $display("max-length frame: out=%0d ok=%0d bad=%0d", out_q.size(), ok_cnt, bad_cnt);
  endtask

  task automatic test_back_to_back();
    int t1;
    do_reset(); clear_mon();
    build_frame(60);
    drive_frame(-1, -1);
    idle(11);
    drive_frame(-1, -1);
    t1 = t0;
    idle(11);
    for (int i = 0; i < 6; i++) begin
      @(posedge mac_clk); #1;
      bus.gmii_rxd = (i == 3) ? 8'h12 : 8'h55; bus.gmii_rx_dv = 1'b1;
    end
    idle(10);
    num_checks++; if (ok_cnt != 2 || bad_cnt != 0) begin num_errors++; $display("FAIL b2b_pulses: got ok=%0d bad=%0d want 2/0", ok_cnt, bad_cnt); end
    num_checks++; if (out_q.size() != 120) begin num_errors++; $display("FAIL b2b_len: got %0d want 120", out_q.size()); end
    num_checks++; if (last_out != t1 + 64) begin num_errors++; $display("FAIL b2b_last: got cycle %0d want %0d", last_out, t1 + 64); end
    num_checks++; if (bus.frames_ok !== 16'd2) begin num_errors++; $display("FAIL b2b_frames_ok: got %0d want 2", bus.frames_ok); end
    num_checks++; if (overlap != 0) begin num_errors++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
    $display("back-to-back: out=%0d ok=%0d bad=%0d frames_ok=%0d", out_q.size(), ok_cnt, bad_cnt, bus.frames_ok);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    build_frame(60);
    drive_frame(-1, -1);
    idle(8);
    clear_mon();
    drive_frame(-1, 30);
    idle(8);
    num_checks++; if (pre_rxdv !== 1'b1) begin num_errors++; $display("FAIL rstmid_pre_rxdv: got %b want 1", pre_rxdv); end
    num_checks++; if (snap_rxdv !== 1'b0 || snap_rxd !== 8'h00) begin num_errors++; $display("FAIL rstmid_outputs: got rxdv=%b rxd=%h want 0/00", snap_rxdv, snap_rxd); end
    num_checks++; if (snap_fok !== 16'd0 || snap_fbad !== 16'd0) begin num_errors++; $display("FAIL rstmid_counters: got ok=%0d bad=%0d want 0/0", snap_fok, snap_fbad); end
    num_checks++; if (out_q.size() != 26) begin num_errors++; $display("FAIL rstmid_len: got %0d want 26", out_q.size()); end
    num_checks++; if (ok_cnt != 0 || bad_cnt != 0) begin num_errors++; $display("FAIL rstmid_pulses: got ok=%0d bad=%0d want 0/0", ok_cnt, bad_cnt); end
    $display("reset mid-frame: out=%0d ok=%0d bad=%0d", out_q.size(), ok_cnt, bad_cnt);
    clear_mon();
    drive_frame(-1, -1);
    idle(8);
    num_checks++; if (out_q.size() != 60 || ok_cnt != 1 || bad_cnt != 0) begin num_errors++; $display("FAIL rstmid_next: got out=%0d ok=%0d bad=%0d want 60/1/0", out_q.size(), ok_cnt, bad_cnt); end
    num_checks++; if (bus.frames_ok !== 16'd1) begin num_errors++; $display("FAIL rstmid_frames_ok: got %0d want 1", bus.frames_ok); end
    $display("frame after reset: out=%0d ok=%0d frames_ok=%0d", out_q.size(), ok_cnt, bus.frames_ok);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_rx_er();
    test_runt();
    test_oversize();
    test_max_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end
endmodule
